// File: rtl/add_4bit_cla.sv
// Registered 4-bit carry-lookahead adder with group P/G outputs for cascading.
// Define ADD_4BIT_CLA_OVF_EN to add the registered signed-overflow output OVF.

module add_4bit_cla_pg (
    input  logic a,
    input  logic b,
    output logic p,
    output logic g
);
    assign p = a ^ b;
    assign g = a & b;
endmodule

module add_4bit_cla (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       PG,
`ifdef ADD_4BIT_CLA_OVF_EN
    output logic       GG,
    output logic       OVF
`else
    output logic       GG
`endif
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] p, g;
    logic [NUM_LANES:0]   c;
    logic [NUM_LANES-1:0] s_nxt;
    logic                 pg_nxt, gg_nxt;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            add_4bit_cla_pg u_pg (
                .a (A[i]),
                .b (B[i]),
                .p (p[i]),
                .g (g[i])
            );
        end
    endgenerate

    // Every carry is a flat sum of products off Cin; no carry feeds another.
    always_comb begin
        c    = '0;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
    end

    assign s_nxt  = p ^ c[3:0];
    assign pg_nxt = &p;
    assign gg_nxt = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            S    <= '0;
            Cout <= 1'b0;
            PG   <= 1'b0;
            GG   <= 1'b0;
        end else begin
            S    <= s_nxt;
            Cout <= c[4];
            PG   <= pg_nxt;
            GG   <= gg_nxt;
        end
    end

`ifdef ADD_4BIT_CLA_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) OVF <= 1'b0;
        else     OVF <= c[3] ^ c[4];
    end
`endif

endmodule

// File: tb/tb_add_4bit_cla.sv
// Directed and exhaustive bench for add_4bit_cla, immediate-assertion checked.
module tb_add_4bit_cla;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B;
    logic       Cin;
    logic [3:0] S;
    logic       Cout, PG, GG;
`ifdef ADD_4BIT_CLA_OVF_EN
    logic       OVF;
`endif

    int checks = 0;
    int errors = 0;

    add_4bit_cla dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .PG   (PG),
`ifdef ADD_4BIT_CLA_OVF_EN
        .GG   (GG),
        .OVF  (OVF)
`else
        .GG   (GG)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands mid-cycle, then sample just after the next rising edge.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(negedge clk);
        rst = r; A = a; B = b; Cin = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] s, input logic co,
                              input logic pg, input logic gg, input logic ovf);
        check({tag, ".S"},    {4'h0, S},    {4'h0, s});
        check({tag, ".Cout"}, {7'h0, Cout}, {7'h0, co});
        check({tag, ".PG"},   {7'h0, PG},   {7'h0, pg});
        check({tag, ".GG"},   {7'h0, GG},   {7'h0, gg});
`ifdef ADD_4BIT_CLA_OVF_EN
        check({tag, ".OVF"},  {7'h0, OVF},  {7'h0, ovf});
`else
        if (ovf === 1'bx) $display("unused ovf");
`endif
    endtask

    initial begin
        logic [4:0] sum;
        logic       pg_m, gg_m, ovf_m;
        int         ssum;
        int         idx;

        rst = 1'b1; A = 4'd0; B = 4'd0; Cin = 1'b0;

        // Reset held for two edges with live operands
        step(1'b1, 4'd7, 4'd9, 1'b1);
        expect_out("rst0", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 4'd9, 1'b1);
        expect_out("rst1", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // 7+9+1=17; bit 0 generates, bits 1..3 propagate
        step(1'b0, 4'd7, 4'd9, 1'b1);
        expect_out("rel", 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

        step(1'b0, 4'd0, 4'd15, 1'b1);
        expect_out("prop1", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd0, 4'd15, 1'b0);
        expect_out("prop0", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'd5, 4'd3, 1'b0);
        expect_out("gen53", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd8, 4'd8, 1'b0);
        expect_out("gen88", 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 4'd15, 4'd15, 1'b1);
        expect_out("max", 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);

        // Exhaustive sweep, one vector per cycle, with a one-edge reset mid-stream
        idx = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    if (idx == 300) begin
                        step(1'b1, a[3:0], b[3:0], ci[0]);
                        expect_out("midrst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                    end
                    step(1'b0, a[3:0], b[3:0], ci[0]);
                    sum   = 5'(a + b + ci);
                    pg_m  = ((a ^ b) == 15);
                    gg_m  = (a + b) > 15;
                    ssum  = (a > 7 ? a - 16 : a) + (b > 7 ? b - 16 : b) + ci;
                    ovf_m = (ssum > 7) || (ssum < -8);
                    expect_out("sweep", sum[3:0], sum[4], pg_m, gg_m, ovf_m);
                    check("inv", {7'h0, Cout}, {7'h0, GG | (PG & ci[0])});
                    idx++;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
